// File: rtl/rotator_scheduler.sv
`timescale 1ns/1ps
// rotator_scheduler
// Two-requester round-robin front end for an external single-step rotator.
// One command is in flight at a time: it is accepted in IDLE, loaded into the
// rotator in LOAD, stepped in ROT until the step count reaches the requested
// amount, and then held in RESP until the consumer takes the result.
module rotator_scheduler #(
    parameter int W     = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_data,
    input  logic             req0_dir,
    input  logic [AMT_W-1:0] req0_amt,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_data,
    input  logic             req1_dir,
    input  logic [AMT_W-1:0] req1_amt,
    // rotator datapath
    output logic             rot_load,
    output logic             rot_dir,
    output logic [W-1:0]     rot_data,
    input  logic [W-1:0]     rot_q,
    // response
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    // 1 means requester 1 was granted most recently, so requester 0 wins a tie
    logic               last_q, last_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic               id_q, id_d;
    logic [W-1:0]       rot_data_q, rot_data_d;
    logic               rot_dir_q, rot_dir_d;
    logic               rot_load_q, rot_load_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [W-1:0]       rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic               busy_q, busy_d;

    logic               gnt0_s, gnt1_s, hs_s;

    // Grant decision: only in IDLE, only from valids and the last-grant pointer.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_q) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0_s = 1'b1;
            end else if (req1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // A grant is only ever raised toward a valid requester, so grant == handshake.
    assign hs_s       = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Next-state and registered-output computation for the command FSM.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        amt_d       = amt_q;
        id_d        = id_q;
        rot_data_d  = rot_data_q;
        rot_dir_d   = rot_dir_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = {AMT_W{1'b0}};
                if (hs_s) begin
                    state_d = S_LOAD;
                    last_d  = gnt1_s;
                    id_d    = gnt1_s;
                    if (gnt1_s) begin
                        rot_data_d = req1_data;
                        rot_dir_d  = req1_dir;
                        amt_d      = req1_amt;
                    end else begin
                        rot_data_d = req0_data;
                        rot_dir_d  = req0_dir;
                        amt_d      = req0_amt;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // rotator takes rot_data on the edge closing this cycle
                state_d = S_ROT;
                cnt_d   = {AMT_W{1'b0}};
            end
            S_ROT: begin
                // rot_q holds the operand rotated cnt_q steps during this cycle
                if (cnt_q == amt_q) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rot_q;
                    rsp_id_d    = id_q;
                end else begin
                    cnt_d = cnt_q + AMT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                cnt_d       = {AMT_W{1'b0}};
            end
        endcase

        // strobe and busy are registered copies of the upcoming state
        rot_load_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers; reset also restores the tie-break pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= {AMT_W{1'b0}};
            amt_q       <= {AMT_W{1'b0}};
            id_q        <= 1'b0;
            rot_data_q  <= {W{1'b0}};
            rot_dir_q   <= 1'b0;
            rot_load_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {W{1'b0}};
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            amt_q       <= amt_d;
            id_q        <= id_d;
            rot_data_q  <= rot_data_d;
            rot_dir_q   <= rot_dir_d;
            rot_load_q  <= rot_load_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign rot_load  = rot_load_q;
    assign rot_dir   = rot_dir_q;
    assign rot_data  = rot_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rotator_scheduler.sv
`timescale 1ns/1ps
// Directed testbench for rotator_scheduler with a behavioural rotator model.
module tb_rotator_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       req0_dir, req1_dir;
    logic [2:0] req0_amt, req1_amt;
    logic       rot_load, rot_dir;
    logic [7:0] rot_data;
    logic [7:0] rot_q;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotator_scheduler #(.W(8), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_dir(req0_dir), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_dir(req1_dir), .req1_amt(req1_amt),
        .rot_load(rot_load), .rot_dir(rot_dir), .rot_data(rot_data), .rot_q(rot_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy)
    );

    // Rotator datapath model: load on strobe, otherwise one step per edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rot_q <= 8'h00;
        else if (rot_load) rot_q <= rot_data;
        else if (rot_dir)  rot_q <= {rot_q[0], rot_q[7:1]};
        else               rot_q <= {rot_q[6:0], rot_q[7]};
    end

    // Waits (bounded) until a handshake is pending, lets it happen, drops that valid.
    task automatic accept_one(output logic gid, output int waited);
        waited = 0;
        #1;
        while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        gid = req1_valid && req1_ready;
        @(posedge clk);
        @(negedge clk);
        if (gid) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
        #1;
    endtask

    // Counts edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    task automatic rsp_handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        req0_dir = 1'b0; req1_dir = 1'b0; req0_amt = 3'd0; req1_amt = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rot_load, rot_dir, rot_data, rsp_valid, rsp_data, rsp_id, busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {rot_load, rot_dir, rot_data, rsp_valid, rsp_data, rsp_id, busy});
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b expected 00", {req0_ready, req1_ready});
        end
    endtask

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       dir;
        logic [2:0] amt;
        logic [7:0] exp;
    } vec_t;

    task automatic test_single_commands();
        vec_t v[6];
        logic gid;
        int   waited, lat;
        v[0] = '{1'b0, 8'h81, 1'b0, 3'd1, 8'h03};
        v[1] = '{1'b1, 8'h81, 1'b1, 3'd2, 8'h60};
        v[2] = '{1'b0, 8'h81, 1'b0, 3'd3, 8'h0C};
        v[3] = '{1'b1, 8'h81, 1'b0, 3'd0, 8'h81};
        v[4] = '{1'b0, 8'hA5, 1'b1, 3'd7, 8'h4B};
        v[5] = '{1'b1, 8'h81, 1'b0, 3'd7, 8'hC0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (v[i].id) begin
                req1_valid = 1'b1; req1_data = v[i].data; req1_dir = v[i].dir; req1_amt = v[i].amt;
            end else begin
                req0_valid = 1'b1; req0_data = v[i].data; req0_dir = v[i].dir; req0_amt = v[i].amt;
            end
            accept_one(gid, waited);
            checks++;
            if (waited >= 20 || gid !== v[i].id) begin
                errors++;
                $display("FAIL vec%0d_grant: got id %b waited %0d expected id %b", i, gid, waited, v[i].id);
            end
            checks++;
            if ({rot_load, rot_dir, rot_data, busy} !== {1'b1, v[i].dir, v[i].data, 1'b1}) begin
                errors++;
                $display("FAIL vec%0d_load: got %h expected %h", i, {rot_load, rot_dir, rot_data, busy}, {1'b1, v[i].dir, v[i].data, 1'b1});
            end
            wait_rsp(lat);
            checks++;
            if (lat !== int'(v[i].amt) + 2) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, int'(v[i].amt) + 2);
            end
            checks++;
            if ({rsp_data, rsp_id, rot_load} !== {v[i].exp, v[i].id, 1'b0}) begin
                errors++;
                $display("FAIL vec%0d_result: got %h/%b load %b expected %h/%b load 0", i, rsp_data, rsp_id, rot_load, v[i].exp, v[i].id);
            end
            rsp_handshake();
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL vec%0d_release: got %b expected 00", i, {rsp_valid, busy});
            end
        end
    endtask

    task automatic test_round_robin();
        logic gid;
        int   waited, lat;
        // fresh pointer so requester 0 wins the first tie
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h01; req0_dir = 1'b0; req0_amt = 3'd1;
        req1_valid = 1'b1; req1_data = 8'h80; req1_dir = 1'b1; req1_amt = 3'd1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL tie1_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        accept_one(gid, waited);
        wait_rsp(lat);
        checks++;
        if ({rsp_valid, rsp_data, rsp_id} !== {1'b1, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL tie1_result: got %b/%h/%b expected 1/02/0", rsp_valid, rsp_data, rsp_id);
        end
        // consumer stalls: result must hold, nobody may be accepted
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready} !== {1'b1, 8'h02, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL stall%0d: got %b/%h/%b rdy %b%b expected 1/02/0 rdy 00", k, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL resp_no_accept: got %b expected 00", {req0_ready, req1_ready});
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_resp_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        // requester 0 returns before the accept: tie again, requester 1 is owed
        req0_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL tie2_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        accept_one(gid, waited);
        wait_rsp(lat);
        checks++;
        if ({rsp_data, rsp_id, lat} !== {8'h40, 1'b1, 32'd3}) begin
            errors++;
            $display("FAIL tie2_result: got %h/%b lat %0d expected 40/1 lat 3", rsp_data, rsp_id, lat);
        end
        rsp_handshake();
        // third tie goes back to requester 0
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL tie3_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        accept_one(gid, waited);
        wait_rsp(lat);
        checks++;
        if ({rsp_data, rsp_id} !== {8'h02, 1'b0}) begin
            errors++;
            $display("FAIL tie3_result: got %h/%b expected 02/0", rsp_data, rsp_id);
        end
        rsp_handshake();
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_abort();
        logic gid;
        int   waited, lat;
        int   seen;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h81; req0_dir = 1'b0; req0_amt = 3'd5;
        accept_one(gid, waited);
        @(negedge clk);      // now in ROT
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rot_load, rot_dir, rot_data, rsp_valid, rsp_data, rsp_id, busy} !== 20'h0) begin
            errors++;
            $display("FAIL abort_reset_outputs: got %h expected 0", {rot_load, rot_dir, rot_data, rsp_valid, rsp_data, rsp_id, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (rsp_valid || busy || req0_ready || req1_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_response: got %0d active cycles expected 0", seen);
        end
        req1_valid = 1'b1; req1_data = 8'h81; req1_dir = 1'b1; req1_amt = 3'd2;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort_fresh_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        accept_one(gid, waited);
        wait_rsp(lat);
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, lat} !== {1'b1, 8'h60, 1'b1, 32'd4}) begin
            errors++;
            $display("FAIL abort_fresh_result: got %b/%h/%b lat %0d expected 1/60/1 lat 4", rsp_valid, rsp_data, rsp_id, lat);
        end
        rsp_handshake();
    endtask

    initial begin
        test_reset();
        test_single_commands();
        test_round_robin();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotator_scheduler.md
ROTATOR_SCHEDULER -- requirements
Module: rotator_scheduler

Interface
REQ-001 Parameter: W, 8, data width of commands, rotator and results.
REQ-002 Parameter: AMT_W, 3, width of rotate-amount field (0..2^AMT_W-1 steps).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req0_valid / req1_valid  input  1  requester N presents a command.
REQ-006 Port: req0_ready / req1_ready  output  1  scheduler accepts requester N's command this cycle.
REQ-007 Port: req0_data / req1_data  input  W  operand.
REQ-008 Port: req0_dir / req1_dir  input  1  0 = rotate left, 1 = rotate right.
REQ-009 Port: req0_amt / req1_amt  input  AMT_W  number of single-bit rotation steps.
REQ-010 Port: rot_load  output  1  load strobe to the rotator datapath.
REQ-011 Port: rot_dir  output  1  direction to the rotator datapath.
REQ-012 Port: rot_data  output  W  load value to the rotator datapath.
REQ-013 Port: rot_q  input  W  rotator output: takes rot_data on an edge with rot_load=1, else rotates one bit per edge per rot_dir.
REQ-014 Port: rsp_valid  output  1  result available.
REQ-015 Port: rsp_ready  input  1  consumer accepts result.
REQ-016 Port: rsp_data  output  W  rotated result.
REQ-017 Port: rsp_id  output  1  requester index (0/1) owning the result.
REQ-018 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, LOAD, ROT, RESP; exactly one command in flight.
REQ-020 Ready: at most one of req0_ready/req1_ready high per cycle, only in IDLE; handshake = valid && ready on a rising edge.
REQ-021 Arbitration: round-robin; sole valid requester wins; both valid -> requester not granted last wins; last-grant pointer updates only on handshake.
REQ-022 Ready is combinational from valids, state and pointer; a requester's ready does not depend on its own data.
REQ-023 On handshake: latch data, dir, amt, id; IDLE -> LOAD.
REQ-024 LOAD (1 cycle): rot_load=1, rot_data=latched data, rot_dir=latched dir; -> ROT, step counter cleared to 0.
REQ-025 ROT: rot_load=0, rot_dir held; in ROT cycle with counter m, rot_q equals operand rotated m steps.
REQ-026 ROT: counter == amt -> capture rot_q into rsp_data, -> RESP; else counter+1; counter is AMT_W bits, never wraps.
REQ-027 amt=0: one ROT cycle, result equals operand unchanged.
REQ-028 Latency: rsp_valid rises amt+2 cycles after the accept edge.
REQ-029 RESP: rsp_valid=1, rsp_data/rsp_id stable until rsp_valid && rsp_ready edge; then -> IDLE.
REQ-030 No new command accepted while in RESP, even if rsp_ready is high (next acceptance earliest one cycle after response handshake).
REQ-031 rot_data and rot_dir outside LOAD/ROT hold last values; rot_load low in every state except LOAD.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, rot_load=0, rot_dir=0, rot_data=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, counter 0, pointer = requester 1 granted last (requester 0 wins first tie).
REQ-033 Reset mid-command aborts it: no response is ever issued for it; readies follow REQ-020 from the first cycle after release.

Verification
REQ-034 req0 0x81, dir 0, amt 1 -> rsp_data 0x03, rsp_id 0, rsp_valid 3 cycles after accept.
REQ-035 req1 0x81, dir 1, amt 2 -> rsp_data 0x60, rsp_id 1; 0x81 dir 0 amt 3 -> 0x0C; amt 0 -> 0x81, latency 2.
REQ-036 Both valid after reset (req0 0x01 L1, req1 0x80 R1) -> req0 served first (0x02, id 0), then req1 (0x40, id 1); repeat -> order alternates.
REQ-037 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; both readies low throughout.
REQ-038 rst_n pulsed low during ROT -> outputs per REQ-032 immediately, no rsp_valid for aborted command, fresh command after release completes correctly.
